// File: rtl/haze_pkg.sv
// Shared widths, sync bundle type and the reciprocal used to fill the recovery LUT.
// Consumed by haze_recip_lut and haze_recovery.
package haze_pkg;

  localparam int PIX_W      = 8;
  localparam int RECIP_W    = 17;
  localparam int PROD_W     = 26;
  localparam int HR_LATENCY = 4;
  localparam int DIFF_W     = PIX_W + 1;
  localparam int SUM_W      = 18;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // round(65536 / t); t = 0 is unreachable once the T0 clamp is applied.
  function automatic logic [RECIP_W-1:0] recip(input logic [PIX_W-1:0] t);
    logic [31:0] q;
    if (t == '0) return '0;
    q = (32'd65536 + 32'(t >> 1)) / 32'(t);
    return q[RECIP_W-1:0];
  endfunction

endpackage

// File: rtl/haze_recip_lut.sv
// 256 x 17 reciprocal ROM with a registered read port (one cycle from idx_i to recip_o).
module haze_recip_lut
  import haze_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   idx_i,
  output logic [RECIP_W-1:0] recip_o
);

  logic [RECIP_W-1:0] rom [256];
  logic [RECIP_W-1:0] recip_q;

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign rom[g] = recip(PIX_W'(g));
  end

  // NOTE: the table itself is constant and never reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (rst) recip_q <= '0;
    else     recip_q <= rom[idx_i];
  end

  assign recip_o = recip_q;

endmodule

// File: rtl/haze_recovery.sv
// Dehaze radiance recovery J = A + (I - A) * 256 / max(t, T0), fixed 4-cycle pipeline.
// Define HAZE_RECOVERY_STATS_EN to build the per-frame clipped-pixel counter behind sat_count.
module haze_recovery
  import haze_pkg::*;
#(
  parameter int T0    = 26,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_src_frame_vsync,
  input  logic             per_src_frame_href,
  input  logic             per_src_frame_clken,
  input  logic [23:0]      per_img,
  input  logic             per_tx_frame_clken,
  input  logic [7:0]       per_tx_img,
  input  logic [7:0]       per_A,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [23:0]      post_img,
  output logic             align_err,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [PIX_W-1:0] T0_L = PIX_W'(T0);

  sync_t                    sync_q [HR_LATENCY];
  logic [PIX_W-1:0]         teff_d, teff_q;
  logic [2:0][DIFF_W-1:0]   diff_d, diff1_q, diff2_q;
  logic [PIX_W-1:0]         a1_q, a2_q, a3_q;
  logic [RECIP_W-1:0]       recip_w;
  logic [2:0][PROD_W-1:0]   prod_d, prod3_q;
  logic signed [PROD_W-1:0] rnd   [3];
  logic signed [SUM_W-1:0]  sum4  [3];
  logic [2:0][PIX_W-1:0]    pix_d, pix4_q;
  logic                     align_err_q;

  // S1: clamp t so index 0 never reaches the LUT; diff is 9-bit two's complement.
  always_comb begin
    // NOTE: each always_comb output is given a default before any loop or branch, so no latch is inferred.
    diff_d = '0;
    teff_d = (per_tx_img < T0_L) ? T0_L : per_tx_img;
    for (int c = 0; c < 3; c++)
      diff_d[c] = {1'b0, per_img[c*PIX_W +: PIX_W]} - {1'b0, per_A};
  end

  haze_recip_lut u_lut (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (teff_q),
    .recip_o (recip_w)
  );

  // S3: low 26 bits of the product are exact for the signed x unsigned case.
  always_comb begin
    prod_d = '0;
    for (int c = 0; c < 3; c++)
      prod_d[c] = PROD_W'($signed(diff2_q[c])) * $signed(PROD_W'({1'b0, recip_w}));
  end

  // S4: round half-up by adding 128 before the arithmetic (floor) shift, then saturate.
  always_comb begin
    pix_d = '0;
    for (int c = 0; c < 3; c++) begin
      rnd[c]  = ($signed(prod3_q[c]) + 26'sd128) >>> 8;
      sum4[c] = SUM_W'(rnd[c]) + $signed({{(SUM_W-PIX_W){1'b0}}, a3_q});
      if (sum4[c] < 0)        pix_d[c] = '0;
      else if (sum4[c] > 255) pix_d[c] = '1;
      else                    pix_d[c] = sum4[c][PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every stage captures its predecessor's previous value.
    if (rst) begin
      for (int i = 0; i < HR_LATENCY; i++) sync_q[i] <= '0;
      teff_q      <= '0;
      diff1_q     <= '0;
      a1_q        <= '0;
      diff2_q     <= '0;
      a2_q        <= '0;
      prod3_q     <= '0;
      a3_q        <= '0;
      pix4_q      <= '0;
      align_err_q <= 1'b0;
    end else begin
      sync_q[0] <= '{vsync: per_src_frame_vsync, href: per_src_frame_href,
                     clken: per_src_frame_clken};
      for (int i = 1; i < HR_LATENCY; i++) sync_q[i] <= sync_q[i-1];
      teff_q      <= teff_d;
      diff1_q     <= diff_d;
      a1_q        <= per_A;
      diff2_q     <= diff1_q;
      a2_q        <= a1_q;
      prod3_q     <= prod_d;
      a3_q        <= a2_q;
      pix4_q      <= pix_d;
      align_err_q <= align_err_q | (per_src_frame_clken ^ per_tx_frame_clken);
    end
  end

  assign post_frame_vsync = sync_q[HR_LATENCY-1].vsync;
  assign post_frame_href  = sync_q[HR_LATENCY-1].href;
  assign post_frame_clken = sync_q[HR_LATENCY-1].clken;
  assign post_img         = post_frame_clken ? pix4_q : '0;
  assign align_err        = align_err_q;

`ifdef HAZE_RECOVERY_STATS_EN
  logic             clip_d, clip4_q, vs_prev_q, inc, vs_fall;
  logic [CNT_W-1:0] cnt_q, cnt_inc, sat_q;

  always_comb begin
    clip_d = 1'b0;
    for (int c = 0; c < 3; c++)
      if (sum4[c] < 0 || sum4[c] > 255) clip_d = 1'b1;
  end

  // The final pixel's increment is folded into the snapshot taken on vsync fall.
  assign inc     = post_frame_clken & clip4_q;
  assign cnt_inc = (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  assign vs_fall = vs_prev_q & ~post_frame_vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip4_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= '0;
    end else begin
      clip4_q   <= clip_d;
      vs_prev_q <= post_frame_vsync;
      if (vs_fall) begin
        sat_q <= cnt_inc;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_haze_recovery.sv
// Scoreboard bench for haze_recovery: driver queues expected pixels, a negedge monitor checks them.
module tb_haze_recovery;

  localparam int CNT_W = 20;
`ifdef HAZE_RECOVERY_STATS_EN
  localparam int EXP_SAT = 3;
`else
  localparam int EXP_SAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             per_src_frame_vsync, per_src_frame_href, per_src_frame_clken;
  logic [23:0]      per_img;
  logic             per_tx_frame_clken;
  logic [7:0]       per_tx_img, per_A;
  logic             post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0]      post_img;
  logic             align_err;
  logic [CNT_W-1:0] sat_count;

  haze_recovery #(.T0(26), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .per_src_frame_vsync (per_src_frame_vsync),
    .per_src_frame_href  (per_src_frame_href),
    .per_src_frame_clken (per_src_frame_clken),
    .per_img             (per_img),
    .per_tx_frame_clken  (per_tx_frame_clken),
    .per_tx_img          (per_tx_img),
    .per_A               (per_A),
    .post_frame_vsync    (post_frame_vsync),
    .post_frame_href     (post_frame_href),
    .post_frame_clken    (post_frame_clken),
    .post_img            (post_img),
    .align_err           (align_err),
    .sat_count           (sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  tx;
    logic [7:0]  a;
    logic [23:0] img;
    logic [23:0] exp;
  } vec_t;

  typedef struct packed {
    logic [23:0] img;
    logic [31:0] cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t mon_e;
  vec_t vecs [8];
  vec_t junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic drive(input logic vs, input logic hr, input logic sck, input logic tck,
                       input vec_t v, input logic push);
    @(negedge clk);
    per_src_frame_vsync = vs;
    per_src_frame_href  = hr;
    per_src_frame_clken = sck;
    per_tx_frame_clken  = tck;
    per_img             = v.img;
    per_tx_img          = v.tx;
    per_A               = v.a;
    if (push) sb.push_back('{img: v.exp, cyc: 32'(cyc + 4)});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, junk, 1'b0);
    check("sb_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (post_frame_clken) begin
      check("sb_has_entry", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("post_img", post_img, mon_e.img);
        check("latency_cycle", cyc, mon_e.cyc);
      end
    end else begin
      check("img_masked", post_img, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{tx: 8'd128, a: 8'd200, img: 24'hB4B4B4, exp: 24'hA0A0A0},  // nominal, negative diff
      '{tx: 8'd5,   a: 8'd100, img: 24'h6E6E6E, exp: 24'hC6C6C6},  // clamp to T0
      '{tx: 8'd64,  a: 8'd50,  img: 24'hFA0032, exp: 24'hFF0032},  // saturate high and low
      '{tx: 8'd255, a: 8'd128, img: 24'h0080FF, exp: 24'h0080FF},  // lands exactly on 0 and 255
      '{tx: 8'd0,   a: 8'd0,   img: 24'h0A141E, exp: 24'h62C5FF},  // tx = 0 clamped
      '{tx: 8'd25,  a: 8'd255, img: 24'hFFFE00, exp: 24'hFFF500},  // just below T0
      '{tx: 8'd26,  a: 8'd10,  img: 24'h0C0A08, exp: 24'h1E0A00},  // exactly T0, floor of negative
      '{tx: 8'd200, a: 8'd100, img: 24'h963264, exp: 24'hA42464}   // mixed signs
    };
    junk = '{tx: 8'd3, a: 8'd77, img: 24'h123456, exp: 24'h0};

    rst = 1'b1;
    per_src_frame_vsync = 1'b0;
    per_src_frame_href  = 1'b0;
    per_src_frame_clken = 1'b0;
    per_tx_frame_clken  = 1'b0;
    per_img             = '0;
    per_tx_img          = '0;
    per_A               = '0;
    repeat (3) @(negedge clk);
    check("rst_vsync", post_frame_vsync, 0);
    check("rst_href", post_frame_href, 0);
    check("rst_clken", post_frame_clken, 0);
    check("rst_img", post_img, 0);
    check("rst_align_err", align_err, 0);
    check("rst_sat_count", sat_count, 0);
    rst = 1'b0;

    // Frame of directed vectors, then junk during clken gaps that must be masked.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[i], 1'b1);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, junk, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[2], 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, junk, 1'b0);
    drain();

    // 100-pixel frame with 3 clipped pixels.
    for (int i = 0; i < 100; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, (i == 10 || i == 50 || i == 99) ? vecs[2] : vecs[0], 1'b1);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b0, junk, 1'b0);
    check("sat_count_clipped", sat_count, EXP_SAT);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b1);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b0, junk, 1'b0);
    check("sat_count_clean", sat_count, 0);
    drain();

    // Source/transmission clken mismatch: flagged next cycle, sticky, data still processed.
    check("align_err_pre", align_err, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, vecs[7], 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, junk, 1'b0);
    check("align_err_set", align_err, 1);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, junk, 1'b0);
    check("align_err_hold", align_err, 1);
    drain();

    // Mid-frame reset: pixel issued 2 cycles before rst must never appear.
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, junk, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, junk, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_vsync", post_frame_vsync, 0);
    check("midrst_href", post_frame_href, 0);
    check("midrst_clken", post_frame_clken, 0);
    check("midrst_img", post_img, 0);
    check("midrst_align_err", align_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_pulse", post_frame_clken, 0);

    // Output resumes with normal latency after reset.
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[3], 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[5], 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/haze_recovery.md
# haze_recovery

- Final stage of the dark-channel-prior dehaze pipeline.
- Consumes the time-aligned source RGB stream, the transmission stream and the atmospheric light A from the alignment stage.
- Computes the recovered scene radiance per channel as J = A + (I − A)·256 / max(t, T0).
- Emits a video stream with the same sync format, delayed by a fixed 4-cycle pipeline.

## Interface
Parameters:
- T0, 26, transmission lower bound (≈0.1 in t/256 scale); legal range 1..255.
- CNT_W, 20, width of saturation counter (stats build only).

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- per_src_frame_vsync  in  1  source vsync, high during frame.
- per_src_frame_href  in  1  source line valid.
- per_src_frame_clken  in  1  source pixel valid.
- per_img  in  24  source pixel; R=[23:16], G=[15:8], B=[7:0].
- per_tx_frame_clken  in  1  transmission pixel valid; must equal per_src_frame_clken every cycle.
- per_tx_img  in  8  transmission t, value/256.
- per_A  in  8  atmospheric light, sampled per pixel.
- post_frame_vsync  out  1  vsync delayed 4 cycles.
- post_frame_href  out  1  href delayed 4 cycles.
- post_frame_clken  out  1  clken delayed 4 cycles.
- post_img  out  24  recovered pixel; 0 when post_frame_clken low.
- align_err  out  1  sticky: src/tx clken mismatch seen.
- sat_count  out  CNT_W  clipped-pixel count of last frame (stats build only).

## Operation
- Data pipeline advances every cycle, no stall. Sync signals ride a 4-deep shift register alongside it.
- S1: t_eff = max(per_tx_img, T0); per channel diff_c = I_c − A (9-bit signed); A registered.
- S2: recip = LUT[t_eff] = round(65536 / t_eff), 17-bit unsigned, registered ROM; diff and A forwarded.
- S3: prod_c = diff_c × recip (26-bit signed).
- S4: q_c = (prod_c + 128) >>> 8 (arithmetic, floor). Then s_c = q_c + A (18-bit signed). Saturate to [0,255] and register.
- A channel is clipped if s_c < 0 or s_c > 255. A pixel is clipped if any of its channels is clipped.
- align_err is set on any cycle where per_src_frame_clken ≠ per_tx_frame_clken. It is cleared only by rst. Data is still processed using the src sync.

## Timing
- Latency: input on cycle N appears at post_* on cycle N+4; throughput 1 pixel/cycle.
- Reset values: post_frame_vsync, post_frame_href, post_frame_clken = 0; post_img = 0; align_err = 0; sat_count = 0. All pipeline and sync stages are cleared.
- Reset mid-frame: outputs are 0 the cycle after rst is sampled high. The partial frame is discarded. Outputs resume 4 cycles after the first post-reset valid input.
- When tx < T0, the clamp applies. tx = 0 never indexes the LUT.
- Gaps in clken or href need no special handling; invalid samples flow through and are masked at output.

## Configuration
- HAZE_RECOVERY_STATS_EN defined:
  - An internal CNT_W counter increments on each output cycle with post_frame_clken=1 and a clipped pixel. It saturates at all-ones.
  - On the falling edge of post_frame_vsync, sat_count is loaded with counter + same-cycle increment, and the counter clears.
  - sat_count updates one cycle after the edge.
- Undefined: no counter logic; sat_count is tied to 0.

## Structure
- Package haze_pkg: PIX_W=8, RECIP_W=17, PROD_W=26, HR_LATENCY=4, and the recip function used to initialise the LUT.
- Sub-module haze_recip_lut: 256×17 registered ROM, index t_eff, 1-cycle read.

## Test plan
- tx=128, A=200, I=(180,180,180) → recip=512, post_img=(160,160,160), 4 cycles after input clken.
- Clamp: tx=5, T0=26, A=100, I=(110,110,110) → recip=2521, post_img=(198,198,198).
- Saturation: tx=64, A=50, I=(250,0,50) → post_img=(255,0,50).
- Sync/reset: clken pulse at cycle 10 → post_frame_clken at cycle 14. rst asserted at cycle 12 → all outputs 0 from cycle 13, no pulse at 14.
- Mismatch: src clken=1 with tx clken=0 for one cycle → align_err=1 next cycle, held until rst.
- Stats (macro on): frame with 3 clipped pixels among 100 → sat_count=3 one cycle after post vsync falls. Next clean frame → sat_count=0.
